// File: rtl/ether_tx_sched.sv
// Two-source frame scheduler for the ether_tx command port: round-robin grant,
// SETSIZE / SETDATA* / SEND sequencing over the etx_ready toggle handshake.
module ether_tx_sched #(
  parameter logic [31:0] XOR_INIT  = 32'hffffffff,
  parameter int          MAX_WORDS = 376,
  parameter int          TIMEOUT   = 4096
) (
  input  logic        ets_clk,
  input  logic        ets_rst_n,
  input  logic [1:0]  ets_req,
  input  logic [8:0]  ets_size0,
  input  logic [8:0]  ets_size1,
  input  logic [31:0] ets_data0,
  input  logic [31:0] ets_data1,
  input  logic [1:0]  ets_valid,
  output logic [1:0]  ets_take,
  output logic [1:0]  ets_done,
  output logic [1:0]  ets_err,
  output logic        ets_busy,
  output logic        etx_cs,
  output logic [3:0]  etx_cmd,
  output logic [31:0] etx_data,
  input  logic        etx_ready
);

  localparam int              WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LOAD  = WD_W'(TIMEOUT);
  localparam logic [8:0]      MAX_SIZE = 9'(MAX_WORDS);

  localparam logic [3:0] CMD_SETSIZE = 4'd1;
  localparam logic [3:0] CMD_SETDATA = 4'd2;
  localparam logic [3:0] CMD_SEND    = 4'd3;
  localparam logic [3:0] CMD_SETXOR  = 4'd4;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CHECK,
    S_SETSIZE,
    S_WAITW,
    S_SETDATA,
    S_SEND,
    S_DONE
  } state_t;

  state_t          state;
  logic            issuing;
  logic            rdy_ref;
  logic [WD_W-1:0] wd;
  logic            grant;
  logic            rr_ptr;
  logic [8:0]      size_q;
  logic [8:0]      words_left;

  logic ack;
  logic pick;

  assign ack = issuing && (etx_ready != rdy_ref);

  // rr_ptr names the requester that wins when both are asking.
  always_comb begin
    pick = ets_req[1];
    if (ets_req == 2'b11) pick = rr_ptr;
  end

  always_ff @(posedge ets_clk) begin
    if (!ets_rst_n) begin
      state      <= S_INIT;
      issuing    <= 1'b0;
      rdy_ref    <= etx_ready;
      wd         <= '0;
      grant      <= 1'b0;
      rr_ptr     <= 1'b0;
      size_q     <= '0;
      words_left <= '0;
      ets_take   <= '0;
      ets_done   <= '0;
      ets_err    <= '0;
      ets_busy   <= 1'b0;
      etx_cs     <= 1'b0;
      etx_cmd    <= '0;
      etx_data   <= '0;
    end else begin
      ets_take <= '0;
      ets_done <= '0;
      ets_err  <= '0;
      if (issuing) begin
        // cs must fall in the acknowledge cycle or ether_tx re-executes the command.
        if (ack) begin
          etx_cs  <= 1'b0;
          rdy_ref <= etx_ready;
          issuing <= 1'b0;
          case (state)
            S_INIT:    state <= S_IDLE;
            S_SETSIZE: state <= S_WAITW;
            S_SETDATA: begin
              words_left <= words_left - 9'd1;
              state      <= (words_left == 9'd1) ? S_SEND : S_WAITW;
            end
            S_SEND:    state <= S_DONE;
            default:   state <= S_IDLE;
          endcase
        end else if (wd == '0) begin
          etx_cs  <= 1'b0;
          rdy_ref <= etx_ready;
          issuing <= 1'b0;
          if (state != S_INIT) begin
            ets_done[grant] <= 1'b1;
            ets_err[grant]  <= 1'b1;
            ets_busy        <= 1'b0;
            rr_ptr          <= ~grant;
            state           <= S_IDLE;
          end
        end else begin
          wd <= wd - 1'b1;
        end
      end else begin
        case (state)
          S_INIT: begin
            etx_cmd  <= CMD_SETXOR;
            etx_data <= XOR_INIT;
            etx_cs   <= 1'b1;
            wd       <= WD_LOAD;
            issuing  <= 1'b1;
          end
          S_IDLE: begin
            if (ets_req != 2'b00) begin
              grant    <= pick;
              ets_busy <= 1'b1;
              size_q   <= pick ? ets_size1 : ets_size0;
              state    <= S_CHECK;
            end
          end
          S_CHECK: begin
            // Rejected frames still hand the tie-break to the other requester.
            if ((size_q == 9'd0) || (size_q > MAX_SIZE)) begin
              ets_done[grant] <= 1'b1;
              ets_err[grant]  <= 1'b1;
              ets_busy        <= 1'b0;
              rr_ptr          <= ~grant;
              state           <= S_IDLE;
            end else begin
              words_left <= size_q;
              state      <= S_SETSIZE;
            end
          end
          S_SETSIZE: begin
            etx_cmd  <= CMD_SETSIZE;
            etx_data <= {23'b0, size_q};
            etx_cs   <= 1'b1;
            wd       <= WD_LOAD;
            issuing  <= 1'b1;
          end
          S_WAITW: begin
            if (ets_valid[grant]) begin
              etx_data        <= grant ? ets_data1 : ets_data0;
              ets_take[grant] <= 1'b1;
              state           <= S_SETDATA;
            end
          end
          S_SETDATA: begin
            etx_cmd <= CMD_SETDATA;
            etx_cs  <= 1'b1;
            wd      <= WD_LOAD;
            issuing <= 1'b1;
          end
          S_SEND: begin
            etx_cmd  <= CMD_SEND;
            etx_data <= '0;
            etx_cs   <= 1'b1;
            wd       <= WD_LOAD;
            issuing  <= 1'b1;
          end
          S_DONE: begin
            ets_done[grant] <= 1'b1;
            ets_busy        <= 1'b0;
            rr_ptr          <= ~grant;
            state           <= S_IDLE;
          end
          default: state <= S_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ether_tx_sched.sv
// Directed bench for ether_tx_sched: toggle-ack ether_tx model, two requesters,
// command and done/err scoreboards checked with immediate assertions.
module tb_ether_tx_sched;

  localparam int TIMEOUT = 4096;

  logic        ets_clk;
  logic        ets_rst_n;
  logic [1:0]  ets_req;
  logic [8:0]  ets_size0;
  logic [8:0]  ets_size1;
  logic [31:0] ets_data0;
  logic [31:0] ets_data1;
  logic [1:0]  ets_valid;
  logic [1:0]  ets_take;
  logic [1:0]  ets_done;
  logic [1:0]  ets_err;
  logic        ets_busy;
  logic        etx_cs;
  logic [3:0]  etx_cmd;
  logic [31:0] etx_data;
  logic        etx_ready;

  int checks = 0;
  int errors = 0;

  logic [35:0] exp_cmd_q[$];
  logic [3:0]  exp_done_q[$];

  int tk0 = 0;
  int tk1 = 0;
  int exp_tk0 = 0;
  int exp_tk1 = 0;
  int burst_cnt = 0;
  int last_len = 0;
  int ack_delay = 30;
  logic mute_data = 1'b0;

  assign ets_data0 = 32'hA000_0000 + 32'(tk0);
  assign ets_data1 = 32'hB100_0000 + 32'(tk1);

  ether_tx_sched #(
    .XOR_INIT (32'hffffffff),
    .MAX_WORDS(376),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .ets_clk  (ets_clk),
    .ets_rst_n(ets_rst_n),
    .ets_req  (ets_req),
    .ets_size0(ets_size0),
    .ets_size1(ets_size1),
    .ets_data0(ets_data0),
    .ets_data1(ets_data1),
    .ets_valid(ets_valid),
    .ets_take (ets_take),
    .ets_done (ets_done),
    .ets_err  (ets_err),
    .ets_busy (ets_busy),
    .etx_cs   (etx_cs),
    .etx_cmd  (etx_cmd),
    .etx_data (etx_data),
    .etx_ready(etx_ready)
  );

  initial begin
    ets_clk = 1'b0;
    forever #5 ets_clk = ~ets_clk;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] req, input logic [8:0] s0, input logic [8:0] s1);
    ets_size0 = s0;
    ets_size1 = s1;
    ets_req   = req;
  endtask

  task automatic push_cmd(input logic [3:0] cmd, input logic [31:0] data);
    exp_cmd_q.push_back({cmd, data});
  endtask

  task automatic push_frame(input int r, input int size);
    push_cmd(4'd1, 32'(size));
    for (int i = 0; i < size; i++) begin
      if (r == 0) begin
        push_cmd(4'd2, 32'hA000_0000 + 32'(exp_tk0));
        exp_tk0++;
      end else begin
        push_cmd(4'd2, 32'hB100_0000 + 32'(exp_tk1));
        exp_tk1++;
      end
    end
    push_cmd(4'd3, 32'h0);
    exp_done_q.push_back({(r == 0) ? 2'b01 : 2'b10, 2'b00});
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge ets_clk);
      n++;
    end while (ets_done == 2'b00 && n < budget);
    check_output({tag, "_done_in_budget"}, 64'(n >= budget), 64'(0));
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge ets_clk);
      n++;
    end while ((exp_cmd_q.size() != 0 || exp_done_q.size() != 0 || ets_busy || etx_cs) && n < budget);
    check_output({tag, "_quiet_in_budget"}, 64'(n >= budget), 64'(0));
  endtask

  // ether_tx model: samples cs on negedge, toggles etx_ready ack_delay cycles later.
  initial begin
    int   cnt = 0;
    int   cs_len = 0;
    logic pending = 1'b0;
    logic hold = 1'b0;
    logic chk_drop = 1'b0;
    logic mute_now = 1'b0;
    etx_ready = 1'b0;
    forever begin
      @(negedge ets_clk);
      if (!ets_rst_n) begin
        pending = 1'b0; hold = 1'b0; chk_drop = 1'b0; cs_len = 0;
      end else begin
        if (etx_cs) cs_len++;
        else if (cs_len != 0) begin
          last_len = cs_len;
          cs_len = 0;
        end
        if (chk_drop) begin
          check_output("cs_drop_after_ack", 64'(etx_cs), 64'(0));
          chk_drop = 1'b0;
        end
        if (pending) begin
          if (cnt > 1) cnt--;
          else begin
            pending = 1'b0;
            hold = 1'b1;
            if (!mute_now) begin
              etx_ready = ~etx_ready;
              chk_drop = 1'b1;
            end
          end
        end else if (etx_cs && !hold) begin
          burst_cnt++;
          if (exp_cmd_q.size() == 0)
            check_output("cmd_unexpected", {28'h0, etx_cmd, etx_data}, 64'(0));
          else
            check_output("cmd", {28'h0, etx_cmd, etx_data}, {28'h0, exp_cmd_q.pop_front()});
          mute_now = mute_data && (etx_cmd == 4'd2);
          pending = 1'b1;
          cnt = ack_delay;
        end else if (hold && !etx_cs) begin
          hold = 1'b0;
        end
      end
    end
  end

  // Requesters advance on take; done/err pulses are scoreboarded here.
  initial begin
    logic [1:0] prev_take = 2'b00;
    forever begin
      @(negedge ets_clk);
      if (ets_rst_n) begin
        if (ets_take != 2'b00)
          check_output("take_one_cycle", 64'(ets_take & prev_take), 64'(0));
        if (ets_take[0]) tk0++;
        if (ets_take[1]) tk1++;
        if (ets_done != 2'b00 || ets_err != 2'b00) begin
          if (exp_done_q.size() == 0)
            check_output("done_unexpected", 64'({ets_done, ets_err}), 64'(0));
          else
            check_output("done_err", 64'({ets_done, ets_err}), 64'(exp_done_q.pop_front()));
        end
        prev_take = ets_take;
      end else begin
        prev_take = 2'b00;
      end
    end
  end

  initial begin
    int t0;
    int base;
    int n;
    ets_rst_n = 1'b0;
    ets_valid = 2'b11;
    apply_stimulus(2'b00, 9'd0, 9'd0);
    push_cmd(4'd4, 32'hffffffff);
    repeat (2) @(negedge ets_clk);
    check_output("rst_cs", 64'(etx_cs), 64'(0));
    check_output("rst_cmd", 64'(etx_cmd), 64'(0));
    check_output("rst_data", 64'(etx_data), 64'(0));
    check_output("rst_take", 64'(ets_take), 64'(0));
    check_output("rst_done", 64'(ets_done), 64'(0));
    check_output("rst_err", 64'(ets_err), 64'(0));
    check_output("rst_busy", 64'(ets_busy), 64'(0));
    ets_rst_n = 1'b1;
    wait_quiet(500, "init");
    check_output("init_bursts", 64'(burst_cnt), 64'(1));
    check_output("init_cs", 64'(etx_cs), 64'(0));
    check_output("init_busy", 64'(ets_busy), 64'(0));

    ack_delay = 3;
    t0 = tk0;
    push_frame(0, 3);
    apply_stimulus(2'b01, 9'd3, 9'd0);
    wait_done(2000, "single");
    ets_req = 2'b00;
    wait_quiet(200, "single");
    check_output("single_takes", 64'(tk0 - t0), 64'(3));

    $display("[TB] both requesters from reset");
    ets_rst_n = 1'b0;
    repeat (2) @(negedge ets_clk);
    push_cmd(4'd4, 32'hffffffff);
    ets_rst_n = 1'b1;
    push_frame(0, 2);
    push_frame(1, 2);
    push_frame(0, 2);
    apply_stimulus(2'b11, 9'd2, 9'd2);
    wait_done(2000, "rr_a");
    wait_done(2000, "rr_b");
    wait_done(2000, "rr_c");
    ets_req = 2'b00;
    wait_quiet(200, "rr");

    base = burst_cnt;
    exp_done_q.push_back({2'b10, 2'b10});
    apply_stimulus(2'b10, 9'd0, 9'd0);
    wait_done(100, "size0");
    ets_req = 2'b00;
    @(negedge ets_clk);
    exp_done_q.push_back({2'b10, 2'b10});
    apply_stimulus(2'b10, 9'd0, 9'd400);
    wait_done(100, "size400");
    ets_req = 2'b00;
    wait_quiet(100, "illegal");
    check_output("illegal_no_cs", 64'(burst_cnt - base), 64'(0));

    $display("[TB] watchdog abort");
    mute_data = 1'b1;
    push_cmd(4'd1, 32'd1);
    push_cmd(4'd2, 32'hA000_0000 + 32'(exp_tk0));
    exp_tk0++;
    exp_done_q.push_back({2'b01, 2'b01});
    apply_stimulus(2'b01, 9'd1, 9'd0);
    wait_done(TIMEOUT + 500, "timeout");
    ets_req = 2'b00;
    @(negedge ets_clk);
    mute_data = 1'b0;
    check_output("timeout_cs_len", 64'(last_len), 64'(TIMEOUT + 1));
    wait_quiet(200, "timeout");
    push_frame(0, 2);
    apply_stimulus(2'b01, 9'd2, 9'd0);
    wait_done(2000, "after_timeout");
    ets_req = 2'b00;
    wait_quiet(200, "after_timeout");

    $display("[TB] reset mid-frame");
    base = burst_cnt;
    push_cmd(4'd1, 32'd5);
    push_cmd(4'd2, 32'hA000_0000 + 32'(exp_tk0));
    push_cmd(4'd2, 32'hA000_0001 + 32'(exp_tk0));
    exp_tk0 += 2;
    t0 = tk0;
    apply_stimulus(2'b01, 9'd5, 9'd0);
    n = 0;
    while (burst_cnt < base + 3 && n < 500) begin
      @(negedge ets_clk);
      n++;
    end
    check_output("mid_reached_setdata", 64'(burst_cnt - base), 64'(3));
    check_output("mid_cs_high", 64'(etx_cs), 64'(1));
    check_output("mid_cmd", 64'(etx_cmd), 64'(2));
    ets_rst_n = 1'b0;
    ets_req = 2'b00;
    @(negedge ets_clk);
    check_output("mid_rst_cs", 64'(etx_cs), 64'(0));
    check_output("mid_rst_busy", 64'(ets_busy), 64'(0));
    check_output("mid_cmds_consumed", 64'(exp_cmd_q.size()), 64'(0));
    @(negedge ets_clk);
    push_cmd(4'd4, 32'hffffffff);
    ets_rst_n = 1'b1;
    check_output("mid_takes", 64'(tk0 - t0), 64'(2));
    wait_quiet(500, "mid_setxor");
    push_frame(0, 1);
    apply_stimulus(2'b01, 9'd1, 9'd0);
    wait_done(2000, "post_reset");
    ets_req = 2'b00;
    wait_quiet(200, "post_reset");

    repeat (5) @(negedge ets_clk);
    check_output("end_cmd_q", 64'(exp_cmd_q.size()), 64'(0));
    check_output("end_done_q", 64'(exp_done_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ether_tx_sched.md
Name: ether_tx_sched

Overview:
- Frame scheduler that shares one ether_tx command port between two frame sources (requesters 0 and 1).
- Arbitrates round-robin and takes the granted frame through the command sequence SETSIZE, then N×SETDATA, then SEND.
- Observes the ether_tx toggle handshake (etx_ready) for every command.
- Issues SETXOR once after reset and reports per-frame completion or error back to the requester.

Parameters:
- XOR_INIT, 32'hffffffff, value written with SETXOR after reset.
- MAX_WORDS, 376, largest legal frame size in 32-bit words; must be ≤511.
- TIMEOUT, 4096, cycles to wait for an etx_ready toggle before abort.

Ports:
- ets_clk  in  1  clock; same clock that drives etx_clk (ether_tx samples on negedge, this block on posedge).
- ets_rst_n  in  1  synchronous active-low reset.
- ets_req  in  2  per-requester frame request; level, held until done.
- ets_size0, ets_size1  in  9 each  frame size in words; stable while req is high.
- ets_data0, ets_data1  in  32 each  current word from requester.
- ets_valid  in  2  per-requester data-word valid.
- ets_take  out  2  one-cycle pulse: word consumed, requester advances.
- ets_done  out  2  one-cycle pulse: frame finished (sent or rejected).
- ets_err  out  2  one-cycle pulse, coincident with done: frame rejected or aborted.
- ets_busy  out  1  high from grant until done.
- etx_cs  out  1  command strobe to ether_tx.
- etx_cmd  out  4  command code: 1 = SETSIZE, 2 = SETDATA, 3 = SEND, 4 = SETXOR.
- etx_data  out  32  command argument.
- etx_ready  in  1  toggle acknowledge from ether_tx.

Behaviour:
- Reset values (ets_rst_n low at posedge):
  - Outputs: etx_cs=0, etx_cmd=0, etx_data=0, ets_take=0, ets_done=0, ets_err=0, ets_busy=0.
  - Round-robin pointer = 0, so requester 0 has priority first.
  - State = S_INIT.
  - rdy_ref ← etx_ready. ether_tx has no reset, so its toggle phase is unknown.
- Command issue (ISSUE sub-sequence, used for every command):
  - Drive etx_cmd/etx_data, set etx_cs=1, load watchdog = TIMEOUT.
  - Hold cmd, data and cs until etx_ready != rdy_ref.
  - In that cycle: etx_cs←0, rdy_ref←etx_ready, proceed.
  - cs must drop in the acknowledge cycle, because ether_tx re-enters IDLE about 26 clocks later and would re-execute a held command.
- Watchdog: if it reaches 0 during ISSUE:
  - etx_cs←0, rdy_ref←etx_ready.
  - If a frame is granted: done+err pulse to it, then S_IDLE.
  - In S_INIT: retry SETXOR.
- States:
  - S_INIT: ISSUE SETXOR with data XOR_INIT, then S_IDLE.
  - S_IDLE: if ets_req != 0, grant the requester per round-robin (the last-served requester loses a tie), set ets_busy=1, latch size → S_CHECK.
  - S_CHECK: size==0 or size>MAX_WORDS → done+err pulse, busy←0, S_IDLE; no command issued. Otherwise words_left←size → S_SETSIZE.
  - S_SETSIZE: ISSUE SETSIZE with data {23'b0, size} → S_WAITW.
  - S_WAITW: wait for valid[g]. Capture data[g] into etx_data, pulse take[g] for exactly one cycle → S_SETDATA. No watchdog on requester stall.
  - S_SETDATA: ISSUE SETDATA, words_left−1. If the result is 0 → S_SEND, else → S_WAITW.
  - S_SEND: ISSUE SEND with data 0. The acknowledge toggle arrives at ether_tx end-of-frame (after FCS) → S_DONE.
  - S_DONE: done[g] pulse, busy←0, pointer←other requester → S_IDLE.
- Byte order: etx_data is passed unchanged; ether_tx performs the byte swap.
- Deassertion of ets_req mid-frame is ignored; the frame completes.
- Latency:
  - From acknowledge to next cs: 1 cycle (next command) or 2 cycles (via S_WAITW when valid is already high).
  - Minimum per-command cost is dominated by the ether_tx interframe of about 26 cycles.
- Reset mid-operation:
  - Immediate return to reset values, and SETXOR is reissued.
  - Any partially loaded frame is abandoned: the next SETSIZE resets the ether_tx write address.
  - No done pulse is issued for the abandoned frame.

Test Plan:
- Reset then idle: an ether_tx model acks SETXOR after 30 cycles → exactly one cs burst with cmd=4, data=32'hffffffff, then etx_cs=0 and busy=0.
- Single frame, req0, size=3, words A0,A1,A2 always valid:
  - Command sequence is SETSIZE(3), SETDATA A0, SETDATA A1, SETDATA A2, SEND.
  - take0 pulses 3 times.
  - done0 pulses once after the SEND acknowledge; err0=0.
- Both requesters held high with size=2 each, from reset:
  - Order is req0 frame, then req1 frame, then req0 frame.
  - Commands of different frames are never interleaved.
- Illegal sizes, req1 size=0 then size=400: each gives done1+err1 in the same cycle, with no etx_cs assertion.
- Timeout: the model never toggles after SETDATA → cs drops after TIMEOUT cycles, done0+err0 pulse, and the next request proceeds normally.
- Reset asserted during S_SETDATA of a 5-word frame: cs=0 on the next cycle, no done pulse, SETXOR reissued, and a following size=1 frame completes correctly.
